// File: rtl/pair_sort_ctrl.sv
// pair_sort_ctrl: sequences an external pair-register unit to order one pair of values.
// A pair is captured in IDLE and loaded into the unit. The unit's contents are compared,
// and the unit is told to exchange them when they are out of order. The result is then
// held for the downstream handshake.
module pair_sort_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter bit DESCEND    = 1'b0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic [DATA_WIDTH-1:0] in_data_2,
    output logic                  load,
    output logic                  swap,
    output logic [DATA_WIDTH-1:0] ld_data_1,
    output logic [DATA_WIDTH-1:0] ld_data_2,
    input  logic [DATA_WIDTH-1:0] sw_data_1,
    input  logic [DATA_WIDTH-1:0] sw_data_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data_1,
    output logic [DATA_WIDTH-1:0] out_data_2,
    output logic                  swapped,
    input  logic                  clr_cnt,
    output logic [CNT_WIDTH-1:0]  pair_count,
    output logic [CNT_WIDTH-1:0]  swap_count,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, LOAD, CMP, SWAP, OUT} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ld_data_1_q, ld_data_2_q;
    logic                  swapped_q;
    logic [CNT_WIDTH-1:0]  pair_cnt_q, pair_cnt_d;
    logic [CNT_WIDTH-1:0]  swap_cnt_q, swap_cnt_d;
    logic                  need_swap;
    logic                  accept;
    logic                  pair_inc;
    logic                  swap_inc;

    // Equal values never swap: both compares are strict.
    assign need_swap = DESCEND ? (sw_data_1 < sw_data_2) : (sw_data_1 > sw_data_2);

    // rst_n is gated in so that in_ready reads 0 while reset is held.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign pair_inc  = (state_q == OUT) && out_ready;
    assign swap_inc  = (state_q == CMP) && need_swap;

    assign load       = (state_q == LOAD);
    assign swap       = (state_q == SWAP);
    assign out_valid  = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign out_data_1 = sw_data_1;
    assign out_data_2 = sw_data_2;
    assign ld_data_1  = ld_data_1_q;
    assign ld_data_2  = ld_data_2_q;
    assign swapped    = swapped_q;
    assign pair_count = pair_cnt_q;
    assign swap_count = swap_cnt_q;

    // Next state, plus saturating counters where a clear beats an increment.
    always_comb begin
        state_d    = state_q;
        pair_cnt_d = clr_cnt ? '0 : (pair_inc && pair_cnt_q != '1) ? pair_cnt_q + 1'b1 : pair_cnt_q;
        swap_cnt_d = clr_cnt ? '0 : (swap_inc && swap_cnt_q != '1) ? swap_cnt_q + 1'b1 : swap_cnt_q;
        case (state_q)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD:    state_d = CMP;
            CMP:     state_d = need_swap ? SWAP : OUT;
            SWAP:    state_d = OUT;
            OUT:     state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    // Registers: reset discards any pair in flight and clears the statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_data_1_q <= '0;
            ld_data_2_q <= '0;
            swapped_q   <= 1'b0;
            pair_cnt_q  <= '0;
            swap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pair_cnt_q <= pair_cnt_d;
            swap_cnt_q <= swap_cnt_d;
            if (accept) begin
                ld_data_1_q <= in_data_1;
                ld_data_2_q <= in_data_2;
            end
            if (state_q == CMP) swapped_q <= need_swap;
        end
    end

endmodule
